tx_fire_sequencer: RTL and testbench
====================================

Name: tx_fire_sequencer

Overview:
Controller for a bank of NUM_CH transducer output channels sharing one 2-bit command bus and one timebase counter. It arms the channels and fires a programmed number of pulse repetitions at a fixed interval. It checks that every channel finishes before the next repetition, and collects channel errors into a sticky fault. It sits between the host register file and the per-channel transducer output modules.

Parameters:
NUM_CH, 8, number of channels driven and monitored
CNTR_W, 32, width of the shared timebase counter and pulseInterval
IDX_W, 16, width of numPulses and pulseIdx

Ports:
clk  in  1  system clock; the block's only clock
reset_n  in  1  asynchronous, active-low reset
start  in  1  level; sampled only in IDLE; starts a burst
abort  in  1  level; ends a burst, takes priority over all other events
clearError  in  1  level; acknowledges FAULT
numPulses  in  IDX_W  repetitions per burst; 0 means start is ignored
pulseInterval  in  CNTR_W  cycles per repetition; values below 2 are treated as 2
chanActive  in  NUM_CH  per-channel isActive
chanError  in  NUM_CH  per-channel errorFlag
txCmd  out  2  command to all channels: 00 wait, 10 fire, 11 reset
cntr  out  CNTR_W  shared timebase
pulseIdx  out  IDX_W  index of the current repetition
busy  out  1  high in ARM and FIRE
done  out  1  one-cycle pulse when a burst completes normally
errorOut  out  1  sticky fault indicator
faultMask  out  NUM_CH  channels that caused the fault (overrun or error)

Behaviour:
- Reset values: txCmd=00, cntr=0, pulseIdx=0, busy=0, done=0, errorOut=0, faultMask=0, state=IDLE. All outputs are registered.
- IDLE: txCmd=00, cntr=0. If start=1 and numPulses!=0, latch numPulses and max(pulseInterval,2) into shadow registers, set pulseIdx=0, go to ARM.
- ARM: txCmd=00 for exactly one cycle, so each channel's cmdState clears. cntr=0. Next state is FIRE.
- FIRE: txCmd=10. cntr increments by 1 every cycle, starting from 0 on the first FIRE cycle.
  - Channels latch on the first FIRE cycle, so chanActive is not checked on that cycle.
  - |chanError on any FIRE cycle: faultMask=chanError, go to FAULT.
  - At cntr==interval-1: if |chanActive, this is an overrun; faultMask=chanActive, go to FAULT.
  - Otherwise, if pulseIdx==numPulses-1, go to DONE; else pulseIdx+1 and go to ARM.
- Repetition period is interval+1 cycles (ARM cycle plus interval FIRE cycles).
- DONE: txCmd=00, done=1 for one cycle, then IDLE. pulseIdx holds its last value until the next start.
- FAULT: txCmd=00 (forces all outputs low), errorOut=1, busy=0. The block stays in FAULT while clearError=0.
  - clearError=1 goes to CLR.
- CLR: txCmd=11 for one cycle, which clears channel errorFlags. errorOut=0, faultMask=0, then IDLE.
- Abort has priority:
  - abort=1 in ARM or FIRE: next cycle txCmd=00, cntr=0, state=IDLE, done stays 0.
  - abort=1 in FAULT is ignored.
- Simultaneous error and last-repetition end: the fault wins.
- start held high re-arms immediately after DONE returns to IDLE, giving one IDLE cycle between bursts.
- cntr never wraps inside a burst because interval ≤ 2^CNTR_W−1. It clears on every ARM.
- An asynchronous reset mid-burst returns every output to its reset value immediately. Channels then see txCmd=00 and drive low.

Optional Feature:
TXSEQ_EXT_TRIG_EN:
- Defined: adds input extTrig (1 bit, asynchronous), synchronized through 2 flops with rising-edge detection. ARM holds txCmd=00 until a synchronized rising edge, then moves to FIRE. abort still applies in ARM.
- Undefined: the port is absent and ARM lasts exactly one cycle.

Decomposition:
- Package tx_seq_pkg holds:
  - the state enum (IDLE, ARM, FIRE, DONE, FAULT, CLR);
  - the command constants CMD_WAIT=2'b00, CMD_FIRE=2'b10, CMD_RESET=2'b11;
  - MIN_INTERVAL=2.
- One sub-module, tx_trig_sync: 2-flop synchronizer plus rising-edge pulse. It is instantiated only under TXSEQ_EXT_TRIG_EN.

Test Plan:
- numPulses=3, interval=10, chanActive pulses for 4 cycles each → 3 ARM/FIRE groups, 11-cycle period, pulseIdx 0,1,2, done at cycle 34 after start, errorOut=0.
- numPulses=2, interval=10, ch3 active through cntr=9 → FAULT, faultMask=0x08, txCmd=00; clearError → one cycle txCmd=11 → IDLE.
- chanError[5]=1 on the 3rd FIRE cycle → FAULT next cycle, faultMask=0x20; abort while in FAULT is ignored.
- abort at cntr=4 of repetition 1 → next cycle txCmd=00, cntr=0, IDLE, no done pulse.
- Boundaries:
  - interval=0 → runs as interval=2;
  - numPulses=0 with start=1 → stays IDLE;
  - reset_n low mid-FIRE → outputs reset without waiting for a clock edge.
- With TXSEQ_EXT_TRIG_EN: ARM waits; an extTrig rising edge → FIRE 3 cycles later (2 sync flops plus the edge register).

Source files
------------

// File: rtl/tx_seq_pkg.sv
// Shared types and constants for the transmit fire sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package tx_seq_pkg;

  // Sequencer states
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARM   = 3'd1,
    FIRE  = 3'd2,
    DONE  = 3'd3,
    FAULT = 3'd4,
    CLR   = 3'd5
  } state_t;

  // Commands broadcast on the shared 2-bit channel bus
  localparam logic [1:0] CMD_WAIT  = 2'b00;
  localparam logic [1:0] CMD_FIRE  = 2'b10;
  localparam logic [1:0] CMD_RESET = 2'b11;

  // Shortest usable repetition interval in FIRE cycles
  localparam int MIN_INTERVAL = 2;

  // Bus command that belongs to each state
  function automatic logic [1:0] cmdForState(input state_t s);
    logic [1:0] cmd;
    cmd = CMD_WAIT;
    case (s)
      FIRE:    cmd = CMD_FIRE;
      CLR:     cmd = CMD_RESET;
      default: cmd = CMD_WAIT;
    endcase
    return cmd;
  endfunction

endpackage

// File: rtl/tx_trig_sync.sv
// External trigger synchronizer: two metastability flops plus a rising-edge pulse.
// Latency: trigPulse is high in the cycle after the second sync flop captures the edge.
// Backpressure: none; edges are not queued, a pulse is lost if nobody is listening.
module tx_trig_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic trigAsync,
  output logic trigPulse
);

  logic trigMeta;
  logic trigSync;
  logic trigSyncDly;

  // Two-flop synchronizer followed by the edge-detect register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      trigMeta    <= 1'b0;
      trigSync    <= 1'b0;
      trigSyncDly <= 1'b0;
    end else begin
      trigMeta    <= trigAsync;
      trigSync    <= trigMeta;
      trigSyncDly <= trigSync;
    end
  end

  // One-cycle pulse on a synchronized low-to-high transition
  assign trigPulse = trigSync & ~trigSyncDly;

endmodule

// File: rtl/tx_fire_sequencer.sv
// Arms a bank of transducer channels and fires numPulses repetitions at a fixed interval,
// collecting channel overruns/errors into a sticky fault. Optional macro: TXSEQ_EXT_TRIG_EN.
// Latency: all outputs registered; repetition period is interval+1 cycles; no backpressure.
module tx_fire_sequencer
  import tx_seq_pkg::*;
#(
  parameter int NUM_CH = 8,
  parameter int CNTR_W = 32,
  parameter int IDX_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic              clearError,
  input  logic [IDX_W-1:0]  numPulses,
  input  logic [CNTR_W-1:0] pulseInterval,
  input  logic [NUM_CH-1:0] chanActive,
  input  logic [NUM_CH-1:0] chanError,
`ifdef TXSEQ_EXT_TRIG_EN
  input  logic              extTrig,
`endif
  output logic [1:0]        txCmd,
  output logic [CNTR_W-1:0] cntr,
  output logic [IDX_W-1:0]  pulseIdx,
  output logic              busy,
  output logic              done,
  output logic              errorOut,
  output logic [NUM_CH-1:0] faultMask
);

  state_t state;
  state_t stateNext;

  // Burst parameters captured at start so host writes mid-burst have no effect.
  // Stored as "last" values so the compare paths need no subtractor.
  logic [CNTR_W-1:0] cntrLastSh;
  logic [IDX_W-1:0]  idxLastSh;

  logic [CNTR_W-1:0] intervalEff;
  logic              burstStart;
  logic              repEnd;
  logic              armGo;
  logic              faultLoad;
  logic [NUM_CH-1:0] faultMaskNext;

  // Intervals below the minimum would make ARM/FIRE degenerate, so clamp them
  assign intervalEff = (pulseInterval < CNTR_W'(MIN_INTERVAL)) ? CNTR_W'(MIN_INTERVAL)
                                                              : pulseInterval;

  assign burstStart = (state == IDLE) && start && (numPulses != '0);
  assign repEnd     = (cntr == cntrLastSh);

`ifdef TXSEQ_EXT_TRIG_EN
  logic trigPulse;

  tx_trig_sync uTrigSync (
    .clk       (clk),
    .reset_n   (reset_n),
    .trigAsync (extTrig),
    .trigPulse (trigPulse)
  );

  assign armGo = trigPulse;
`else
  assign armGo = 1'b1;
`endif

  // Next-state logic; abort beats errors, errors beat overrun, overrun beats completion
  always_comb begin
    stateNext     = state;
    faultLoad     = 1'b0;
    faultMaskNext = '0;
    case (state)
      IDLE: begin
        if (burstStart) stateNext = ARM;
      end
      ARM: begin
        if (abort)      stateNext = IDLE;
        else if (armGo) stateNext = FIRE;
      end
      FIRE: begin
        if (abort) begin
          stateNext = IDLE;
        end else if (|chanError) begin
          stateNext     = FAULT;
          faultLoad     = 1'b1;
          faultMaskNext = chanError;
        end else if (repEnd) begin
          // chanActive is only looked at here; interval>=2 keeps this off the
          // first FIRE cycle, when channels are still latching the command
          if (|chanActive) begin
            stateNext     = FAULT;
            faultLoad     = 1'b1;
            faultMaskNext = chanActive;
          end else if (pulseIdx == idxLastSh) begin
            stateNext = DONE;
          end else begin
            stateNext = ARM;
          end
        end
      end
      DONE:    stateNext = IDLE;
      FAULT: begin
        if (clearError) stateNext = CLR;
      end
      CLR:     stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // State register and registered outputs decoded from the upcoming state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      txCmd    <= CMD_WAIT;
      busy     <= 1'b0;
      done     <= 1'b0;
      errorOut <= 1'b0;
    end else begin
      state    <= stateNext;
      txCmd    <= cmdForState(stateNext);
      busy     <= (stateNext == ARM) || (stateNext == FIRE);
      done     <= (stateNext == DONE);
      errorOut <= (stateNext == FAULT);
    end
  end

  // Timebase: counts from 0 on the first FIRE cycle, zero everywhere else
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cntr <= '0;
    end else if ((state == FIRE) && (stateNext == FIRE)) begin
      cntr <= cntr + CNTR_W'(1);
    end else begin
      cntr <= '0;
    end
  end

  // Repetition index: cleared at burst start, advanced on each FIRE->ARM, held after DONE
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pulseIdx <= '0;
    end else if (burstStart) begin
      pulseIdx <= '0;
    end else if ((state == FIRE) && (stateNext == ARM)) begin
      pulseIdx <= pulseIdx + IDX_W'(1);
    end
  end

  // Shadow copies of the burst parameters, loaded when a burst is accepted
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cntrLastSh <= '0;
      idxLastSh  <= '0;
    end else if (burstStart) begin
      cntrLastSh <= intervalEff - CNTR_W'(1);
      idxLastSh  <= numPulses - IDX_W'(1);
    end
  end

  // Offending channels: captured on fault entry, held through FAULT, cleared otherwise
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      faultMask <= '0;
    end else if (faultLoad) begin
      faultMask <= faultMaskNext;
    end else if (stateNext != FAULT) begin
      faultMask <= '0;
    end
  end

endmodule

// File: tb/tb_tx_fire_sequencer.sv
// Directed bench for tx_fire_sequencer: table of burst shapes plus hand-written corner sequences.
// Latency: outputs sampled 1 time unit after the rising edge; inputs driven at the same point.
// Backpressure: n/a.
module tb_tx_fire_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        abort;
  logic        clearError;
  logic [15:0] numPulses;
  logic [31:0] pulseInterval;
  logic [7:0]  chanActive;
  logic [7:0]  chanError;
  logic [1:0]  txCmd;
  logic [31:0] cntr;
  logic [15:0] pulseIdx;
  logic        busy;
  logic        done;
  logic        errorOut;
  logic [7:0]  faultMask;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  tx_fire_sequencer #(.NUM_CH(8), .CNTR_W(32), .IDX_W(16)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .abort         (abort),
    .clearError    (clearError),
    .numPulses     (numPulses),
    .pulseInterval (pulseInterval),
    .chanActive    (chanActive),
    .chanError     (chanError),
    .txCmd         (txCmd),
    .cntr          (cntr),
    .pulseIdx      (pulseIdx),
    .busy          (busy),
    .done          (done),
    .errorOut      (errorOut),
    .faultMask     (faultMask)
  );

  typedef struct {
    logic [15:0] np;
    logic [31:0] iv;
    int          expDone;   // cycle (after the start-sampling edge) at which done is seen
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept a burst: start is sampled at the next edge, after which the DUT is in ARM (cycle 1)
  task automatic launch(input logic [15:0] np, input logic [31:0] iv);
    numPulses     = np;
    pulseInterval = iv;
    start         = 1'b1;
    tick();
    start         = 1'b0;
  endtask

  // Acknowledge a fault: one CLR cycle then back to IDLE
  task automatic clearFault(input string tag);
    clearError = 1'b1;
    tick();
    clearError = 1'b0;
    check({tag, "_clr_cmd"}, 32'(txCmd), 32'h3);
    check({tag, "_clr_err"}, 32'(errorOut), 32'h0);
    check({tag, "_clr_mask"}, 32'(faultMask), 32'h0);
    tick();
    check({tag, "_idle_cmd"}, 32'(txCmd), 32'h0);
  endtask

  initial begin
    int doneAt;
    int doneCount;

    reset_n       = 1'b0;
    start         = 1'b0;
    abort         = 1'b0;
    clearError    = 1'b0;
    numPulses     = 16'd0;
    pulseInterval = 32'd0;
    chanActive    = 8'h00;
    chanError     = 8'h00;

    // np, interval, expected done cycle = np*(max(iv,2)+1)+1
    vecs[0] = '{np: 16'd3, iv: 32'd10, expDone: 34};
    vecs[1] = '{np: 16'd1, iv: 32'd2,  expDone: 4};
    vecs[2] = '{np: 16'd1, iv: 32'd0,  expDone: 4};
    vecs[3] = '{np: 16'd2, iv: 32'd1,  expDone: 7};
    vecs[4] = '{np: 16'd4, iv: 32'd3,  expDone: 17};
    vecs[5] = '{np: 16'd2, iv: 32'd5,  expDone: 13};

    // Reset state
    #3;
    check("rst_txCmd", 32'(txCmd), 32'h0);
    check("rst_cntr", cntr, 32'h0);
    check("rst_pulseIdx", 32'(pulseIdx), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_errorOut", 32'(errorOut), 32'h0);
    check("rst_faultMask", 32'(faultMask), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    // Table: burst lengths with idle channels
    for (int v = 0; v < 6; v++) begin
      launch(vecs[v].np, vecs[v].iv);
      doneAt = -1;
      for (int k = 1; k <= 300 && doneAt < 0; k++) begin
        if (k > 1) tick();
        if (done) doneAt = k;
      end
      check($sformatf("tbl%0d_done_cycle", v), 32'(doneAt), 32'(vecs[v].expDone));
      check($sformatf("tbl%0d_pulseIdx", v), 32'(pulseIdx), 32'(vecs[v].np - 16'd1));
      check($sformatf("tbl%0d_errorOut", v), 32'(errorOut), 32'h0);
      check($sformatf("tbl%0d_done_cmd", v), 32'(txCmd), 32'h0);
      tick();
      check($sformatf("tbl%0d_idle_busy", v), 32'(busy), 32'h0);
      check($sformatf("tbl%0d_idle_done", v), 32'(done), 32'h0);
    end

    // Cycle-accurate 3x10 burst with channels active for the first 4 FIRE cycles
    launch(16'd3, 32'd10);
    for (int k = 1; k <= 35; k++) begin
      if (k > 1) tick();
      case (k)
        1: begin
          check("b3_arm_cmd", 32'(txCmd), 32'h0);
          check("b3_arm_busy", 32'(busy), 32'h1);
          check("b3_arm_cntr", cntr, 32'h0);
        end
        2: begin
          check("b3_fire0_cmd", 32'(txCmd), 32'h2);
          check("b3_fire0_cntr", cntr, 32'h0);
        end
        11: begin
          check("b3_fire9_cntr", cntr, 32'd9);
          check("b3_fire9_idx", 32'(pulseIdx), 32'h0);
        end
        12: begin
          check("b3_arm1_cmd", 32'(txCmd), 32'h0);
          check("b3_arm1_idx", 32'(pulseIdx), 32'h1);
          check("b3_arm1_busy", 32'(busy), 32'h1);
        end
        24: begin
          check("b3_rep2_cmd", 32'(txCmd), 32'h2);
          check("b3_rep2_idx", 32'(pulseIdx), 32'h2);
        end
        33: check("b3_last_cntr", cntr, 32'd9);
        34: begin
          check("b3_done", 32'(done), 32'h1);
          check("b3_done_busy", 32'(busy), 32'h0);
          check("b3_done_err", 32'(errorOut), 32'h0);
        end
        35: check("b3_done_pulse_len", 32'(done), 32'h0);
        default: ;
      endcase
      chanActive = ((k >= 2 && k <= 5) || (k >= 13 && k <= 16) || (k >= 24 && k <= 27))
                   ? 8'h0F : 8'h00;
    end
    chanActive = 8'h00;

    // Overrun: channel 3 still active at cntr==interval-1
    launch(16'd2, 32'd10);
    chanActive = 8'h08;
    for (int k = 2; k <= 12; k++) begin
      tick();
      if (k == 11) check("ovr_cntr9_cmd", 32'(txCmd), 32'h2);
    end
    check("ovr_fault_err", 32'(errorOut), 32'h1);
    check("ovr_fault_mask", 32'(faultMask), 32'h08);
    check("ovr_fault_cmd", 32'(txCmd), 32'h0);
    check("ovr_fault_busy", 32'(busy), 32'h0);
    chanActive = 8'h00;
    tick();
    tick();
    check("ovr_sticky_err", 32'(errorOut), 32'h1);
    check("ovr_sticky_mask", 32'(faultMask), 32'h08);
    clearFault("ovr");

    // Channel error on the 3rd FIRE cycle; abort in FAULT has no effect
    launch(16'd3, 32'd10);
    tick();   // k=2
    tick();   // k=3
    tick();   // k=4, third FIRE cycle
    chanError = 8'h20;
    tick();   // k=5
    chanError = 8'h00;
    check("err_fault_err", 32'(errorOut), 32'h1);
    check("err_fault_mask", 32'(faultMask), 32'h20);
    check("err_fault_cmd", 32'(txCmd), 32'h0);
    check("err_fault_cntr", cntr, 32'h0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("err_abort_ignored", 32'(errorOut), 32'h1);
    check("err_abort_mask", 32'(faultMask), 32'h20);
    clearFault("err");

    // Error coinciding with the end of the last repetition: fault wins
    launch(16'd1, 32'd2);
    tick();   // k=2, cntr 0
    tick();   // k=3, cntr 1 = last
    chanError = 8'h01;
    tick();
    chanError = 8'h00;
    check("coin_no_done", 32'(done), 32'h0);
    check("coin_fault", 32'(errorOut), 32'h1);
    check("coin_mask", 32'(faultMask), 32'h01);
    clearFault("coin");

    // Abort at cntr=4 of repetition 1
    launch(16'd3, 32'd10);
    for (int k = 2; k <= 17; k++) tick();
    check("abt_pre_cntr", cntr, 32'd4);
    check("abt_pre_idx", 32'(pulseIdx), 32'h1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abt_cmd", 32'(txCmd), 32'h0);
    check("abt_cntr", cntr, 32'h0);
    check("abt_busy", 32'(busy), 32'h0);
    doneCount = 0;
    for (int k = 0; k < 40; k++) begin
      if (done) doneCount++;
      tick();
    end
    check("abt_no_done", 32'(doneCount), 32'h0);
    check("abt_stays_idle", 32'(busy), 32'h0);

    // numPulses=0 ignores start
    numPulses     = 16'd0;
    pulseInterval = 32'd10;
    start         = 1'b1;
    tick();
    tick();
    tick();
    start = 1'b0;
    check("np0_busy", 32'(busy), 32'h0);
    check("np0_cmd", 32'(txCmd), 32'h0);

    // start held high: one IDLE cycle between bursts
    numPulses     = 16'd1;
    pulseInterval = 32'd2;
    start         = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 4) check("hold_done", 32'(done), 32'h1);
      if (k == 5) check("hold_idle_busy", 32'(busy), 32'h0);
      if (k == 6) check("hold_rearm_busy", 32'(busy), 32'h1);
    end
    start = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    check("hold_end_idle", 32'(busy), 32'h0);

    // Asynchronous reset mid-FIRE
    launch(16'd3, 32'd10);
    for (int k = 2; k <= 6; k++) tick();
    check("arst_pre_cmd", 32'(txCmd), 32'h2);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_cmd", 32'(txCmd), 32'h0);
    check("arst_cntr", cntr, 32'h0);
    check("arst_busy", 32'(busy), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    tick();
    check("arst_after_idle", 32'(busy), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
